// File: rtl/toggle_rx_monitor.sv
// Receive-side checker for a free-running d/~d toggle pair: verifies complement
// integrity and per-cycle alternation, acquires lock, counts errors and good toggles.
module toggle_rx_monitor #(
  parameter logic INIT_VAL   = 1'b0,
  parameter int   LOCK_COUNT = 4,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_inv,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] tog_cnt
);

  typedef enum logic [1:0] {FIRST, SEARCH, LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t     state, state_nxt;
  logic       prev;
  logic [3:0] run, run_nxt;
  logic       pair_ok, good, err, tog_inc;

  // The very first sample has no predecessor, so it is judged against INIT_VAL.
  always_comb begin
    pair_ok = (din_inv == ~din);
    good    = pair_ok && ((state == FIRST) ? (din == INIT_VAL) : (din != prev));
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    err       = 1'b0;
    tog_inc   = 1'b0;
    case (state)
      FIRST: begin
        if (good) begin
          if (LOCK_COUNT == 1) begin
            state_nxt = LOCKED;
            run_nxt   = 4'd0;
          end else begin
            state_nxt = SEARCH;
            run_nxt   = 4'd1;
          end
        end else begin
          state_nxt = SEARCH;
          run_nxt   = 4'd0;
          err       = 1'b1;
        end
      end
      SEARCH: begin
        if (good) begin
          if (run + 4'd1 == LOCK_CNT4) begin
            state_nxt = LOCKED;
            run_nxt   = 4'd0;
          end else begin
            run_nxt = run + 4'd1;
          end
        end else begin
          run_nxt = 4'd0;
        end
      end
      LOCKED: begin
        if (good) begin
          tog_inc = 1'b1;
        end else begin
          state_nxt = SEARCH;
          run_nxt   = 4'd0;
          err       = 1'b1;
        end
      end
      default: begin
        state_nxt = FIRST;
        run_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FIRST;
      prev      <= INIT_VAL;
      run       <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      tog_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= din;
      run       <= run_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err;
      // Saturate rather than wrap so a long fault burst stays visible.
      if (err && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
      if (tog_inc)
        tog_cnt <= tog_cnt + 1'b1;
    end
  end

endmodule
